// File: rtl/ac_motor_pkg.sv
// Shared types and sizing for the AC motor PWM decoder: FSM state encoding,
// default counter width and the derived signed duty width.
package ac_motor_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    MEAS  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Duty is a signed difference of two CNT_W-bit counts.
  function automatic int duty_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage

// File: rtl/ac_motor_pwm_decoder_if.sv
// PWM observation bus into the decoder plus its per-period result bus.
interface ac_motor_pwm_decoder_if #(
  parameter int CNT_W = 16
) ();
  import ac_motor_pkg::*;

  logic                            period_start;
  logic                            out1;
  logic                            out2;
  logic                            en1;
  logic                            en2;
  logic signed [duty_w(CNT_W)-1:0] duty;
  logic [CNT_W-1:0]                period;
  logic                            duty_valid;

  // duty_valid is a one-cycle strobe with no ready/backpressure: a consumer
  // must take duty/period on the pulse; both hold their value between pulses.
  modport master (
    output period_start, out1, out2, en1, en2,
    input  duty, period, duty_valid
  );

  modport slave (
    input  period_start, out1, out2, en1, en2,
    output duty, period, duty_valid
  );
endinterface

// File: rtl/ac_motor_sat_counter.sv
// Up-counter with synchronous load and saturation at all-ones.
module ac_motor_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ac_motor_pwm_decoder.sv
// Recovers per-carrier-period signed duty from a gated PWM pair; flags
// shoot-through and missing carrier. AC_MOTOR_PWM_DECODER_AVG_EN enables 4-period averaging.
module ac_motor_pwm_decoder
  import ac_motor_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_PERIOD = 50000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  ac_motor_pwm_decoder_if.slave      bus,
  output logic                       shoot_fault,
  output logic                       timeout_fault,
  output logic [1:0]                 state
);

  localparam int DW = duty_w(CNT_W);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);

  state_t state_q, state_d;

  logic a1, a2, shoot, strobe, over;
  logic cnt_load, cnt_restart, cnt_inc;
  logic capture, set_shoot, set_tmo, clr_fault;
  logic [CNT_W-1:0] cnt_p, cnt1, cnt2;
  logic [CNT_W-1:0] lv_p, lv_1, lv_2;
  logic signed [DW-1:0] raw_duty;
  logic signed [DW-1:0] duty_q;
  logic [CNT_W-1:0]     period_q;
  logic                 valid_q;

  assign a1       = bus.out1 & bus.en1;
  assign a2       = bus.out2 & bus.en2;
  assign shoot    = a1 & a2;
  assign strobe   = bus.period_start;
  assign over     = (cnt_p >= MAX_CNT);
  assign raw_duty = $signed({1'b0, cnt1}) - $signed({1'b0, cnt2});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_restart = 1'b0;
    cnt_inc     = 1'b0;
    capture     = 1'b0;
    set_shoot   = 1'b0;
    set_tmo     = 1'b0;
    clr_fault   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_load = 1'b1;
        if (enable) state_d = SYNC;
      end
      SYNC: begin
        if (shoot) begin
          set_shoot = 1'b1;
          state_d   = FAULT;
        end else if (strobe) begin
          // The strobe cycle belongs to the new period, so the first full
          // period measures the same length as every later one.
          cnt_load    = 1'b1;
          cnt_restart = 1'b1;
          state_d     = MEAS;
        end
      end
      MEAS: begin
        set_shoot = shoot;
        set_tmo   = over && !strobe;
        if (shoot || set_tmo) begin
          state_d = FAULT;
        end else if (strobe) begin
          capture     = 1'b1;
          cnt_load    = 1'b1;
          cnt_restart = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      FAULT: begin
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d     = IDLE;
      cnt_load    = 1'b1;
      cnt_restart = 1'b0;
      cnt_inc     = 1'b0;
      capture     = 1'b0;
      set_shoot   = 1'b0;
      set_tmo     = 1'b0;
      clr_fault   = 1'b1;
    end
  end

  assign lv_p = cnt_restart ? CNT_W'(1) : '0;
  assign lv_1 = {{(CNT_W-1){1'b0}}, cnt_restart & a1};
  assign lv_2 = {{(CNT_W-1){1'b0}}, cnt_restart & a2};

  ac_motor_sat_counter #(.W(CNT_W)) u_cnt_p (
    .clk(clk), .rst_n(rst_n), .load(cnt_load), .load_val(lv_p),
    .inc(cnt_inc), .count(cnt_p)
  );

  ac_motor_sat_counter #(.W(CNT_W)) u_cnt_1 (
    .clk(clk), .rst_n(rst_n), .load(cnt_load), .load_val(lv_1),
    .inc(cnt_inc & a1), .count(cnt1)
  );

  ac_motor_sat_counter #(.W(CNT_W)) u_cnt_2 (
    .clk(clk), .rst_n(rst_n), .load(cnt_load), .load_val(lv_2),
    .inc(cnt_inc & a2), .count(cnt2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shoot_fault   <= 1'b0;
      timeout_fault <= 1'b0;
    end else if (clr_fault) begin
      shoot_fault   <= 1'b0;
      timeout_fault <= 1'b0;
    end else begin
      shoot_fault   <= shoot_fault | set_shoot;
      timeout_fault <= timeout_fault | set_tmo;
    end
  end

`ifdef AC_MOTOR_PWM_DECODER_AVG_EN
  logic signed [DW-1:0]      hist [4];
  logic signed [CNT_W+2:0]   sum_q, sum_d, raw_ext, old_ext, avg_full;
  logic [2:0]                fill_q;

  assign raw_ext  = {{2{raw_duty[DW-1]}}, raw_duty};
  assign old_ext  = {{2{hist[3][DW-1]}}, hist[3]};
  assign sum_d    = sum_q + raw_ext - old_ext;
  assign avg_full = sum_d >>> 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      sum_q    <= '0;
      fill_q   <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= capture && (fill_q >= 3'd3);
      if (state_q == IDLE) begin
        for (int i = 0; i < 4; i++) hist[i] <= '0;
        sum_q  <= '0;
        fill_q <= '0;
      end else if (capture) begin
        hist[0] <= raw_duty;
        for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        sum_q  <= sum_d;
        fill_q <= (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
        if (fill_q >= 3'd3) begin
          duty_q   <= avg_full[DW-1:0];
          period_q <= cnt_p;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= capture;
      if (capture) begin
        duty_q   <= raw_duty;
        period_q <= cnt_p;
      end
    end
  end
`endif

  assign bus.duty       = duty_q;
  assign bus.period     = period_q;
  assign bus.duty_valid = valid_q;
  assign state          = state_q;

endmodule
